// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state encoding,
// port index constants and default bus widths.
// Configuration macro: DMEM_ARB_FIXED_PRI_EN (consumed by dmem_arb_rr).
package dmem_arb_pkg;

   // Default geometry: 64-bit data, 10-bit byte address.
   localparam int DMEM_DATA_W = 64;
   localparam int DMEM_ADDR_W = 10;

   // Port indices: 0 is the CPU, 1 is the debug/dump port.
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   // Arbitration FSM: free arbitration or grant held by one port.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOCK0 = 2'd1,
      ARB_LOCK1 = 2'd2
   } arb_state_e;

   // One-hot grant vector for a port index.
   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

   // Lock state that belongs to a port index.
   function automatic arb_state_e lock_state(input logic port);
      return port ? ARB_LOCK1 : ARB_LOCK0;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter. Both ports are carried as
// 2-element packed vectors indexed by port number (0 = CPU, 1 = debug).
// master: the requesters (drive requests, receive grants and read data).
// slave:  the arbiter.
interface dmem_arbiter_if #(
   parameter int DATA_W = dmem_arb_pkg::DMEM_DATA_W,
   parameter int ADDR_W = dmem_arb_pkg::DMEM_ADDR_W
) ();

   logic [1:0]             req_i;
   logic [1:0]             lock_i;
   logic [1:0]             we_i;
   logic [1:0][ADDR_W-1:0] addr_i;
   logic [1:0][DATA_W-1:0] wdata_i;
   logic [1:0]             gnt_o;
   logic [1:0]             rvalid_o;
   logic [DATA_W-1:0]      rdata_o;

   modport master (
      output req_i, lock_i, we_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, lock_i, we_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );

endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way grant selection for the data-memory arbiter.
// Default build: round-robin with a 1-bit preference pointer rr_q that the
// parent moves to the other port after every unlocked grant.
// With DMEM_ARB_FIXED_PRI_EN defined: CPU port always wins a tie and the
// pointer does not exist; the update inputs are then ignored.
module dmem_arb_rr
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_b,
   input  logic [1:0] req_i,       // raw requests, port 0 = CPU
   input  logic       upd_i,       // an unlocked grant (or lock exit) happened
   input  logic       upd_port_i,  // port that was served
   output logic [1:0] gnt_o        // one-hot candidate grant
);

`ifdef DMEM_ARB_FIXED_PRI_EN

   // Fixed priority: CPU first, debug only when the CPU is quiet.
   always_comb begin
      gnt_o = 2'b00;
      if (req_i[PORT_CPU]) begin
         gnt_o = port_onehot(PORT_CPU);
      end else if (req_i[PORT_DBG]) begin
         gnt_o = port_onehot(PORT_DBG);
      end
   end

   // Pointer-maintenance inputs have no consumer in this build.
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, reset_b, upd_i, upd_port_i};

`else

   logic rr_q;
   logic rr_d;

   // Next pointer: prefer the port that was not just served.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rr_d = rr_q;
      if (upd_i) begin
         rr_d = ~upd_port_i;
      end
   end

   // Pointer register, CPU preferred out of reset.
   always_ff @(posedge clk) begin
      // NOTE: state is only ever written with <= so every flop samples pre-edge values.
      if (!reset_b) begin
         rr_q <= PORT_CPU;
      end else begin
         rr_q <= rr_d;
      end
   end

   // Round-robin pick: a lone requester wins, a tie goes to rr_q.
   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = port_onehot(PORT_CPU);
         2'b10:   gnt_o = port_onehot(PORT_DBG);
         2'b11:   gnt_o = port_onehot(rr_q);
         default: gnt_o = 2'b00;
      endcase
   end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port data memory.
// Grant is combinational in the request cycle and steers the granted port's
// command onto the memory bus. A port can lock the memory for consecutive
// cycles with lock_i. Read data comes back one cycle later on a shared bus,
// qualified per port by a registered one-hot tag (rvalid).
// Configuration macro: DMEM_ARB_FIXED_PRI_EN selects fixed CPU priority
// instead of round-robin (see dmem_arb_rr); lock behaviour is identical.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_b,
   dmem_arbiter_if.slave     bus,
   output logic              mem_cs_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic [1:0] rvalid_q;
   logic [1:0] rvalid_d;

   logic [1:0] rr_gnt;     // candidate grant from free arbitration
   logic [1:0] gnt;        // final grant for this cycle
   logic       upd;        // move the round-robin pointer this cycle
   logic       upd_port;   // port the pointer moves away from
   logic       gnt_port;   // index of the granted port (valid when |gnt)

   dmem_arb_rr u_rr (
      .clk        (clk),
      .reset_b    (reset_b),
      .req_i      (bus.req_i),
      .upd_i      (upd),
      .upd_port_i (upd_port),
      .gnt_o      (rr_gnt)
   );

   // Lock FSM: picks between free arbitration and a held grant.
   always_comb begin
      state_d  = state_q;
      gnt      = 2'b00;
      upd      = 1'b0;
      upd_port = PORT_CPU;

      unique case (state_q)
         ARB_IDLE: begin
            gnt = rr_gnt;
            if (|rr_gnt) begin
               if (bus.lock_i[rr_gnt[PORT_DBG]]) begin
                  // Locked grant: pointer stays put until the lock is released.
                  state_d = lock_state(rr_gnt[PORT_DBG]);
               end else begin
                  upd      = 1'b1;
                  upd_port = rr_gnt[PORT_DBG];
               end
            end
         end

         ARB_LOCK0: begin
            // Only the CPU may be served; the exit cycle still serves it.
            gnt[PORT_CPU] = bus.req_i[PORT_CPU];
            if (!(bus.req_i[PORT_CPU] && bus.lock_i[PORT_CPU])) begin
               state_d  = ARB_IDLE;
               upd      = 1'b1;
               upd_port = PORT_CPU;
            end
         end

         ARB_LOCK1: begin
            // Only the debug port may be served; the exit cycle still serves it.
            gnt[PORT_DBG] = bus.req_i[PORT_DBG];
            if (!(bus.req_i[PORT_DBG] && bus.lock_i[PORT_DBG])) begin
               state_d  = ARB_IDLE;
               upd      = 1'b1;
               upd_port = PORT_DBG;
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      // No access may start while reset is held, whatever the requesters do.
      if (!reset_b) begin
         gnt = 2'b00;
      end
   end

   // Memory command mux and read-tag capture for the granted port.
   always_comb begin
      gnt_port    = gnt[PORT_DBG];
      mem_cs_o    = |gnt;
      mem_we_o    = mem_cs_o & bus.we_i[gnt_port];
      mem_addr_o  = bus.addr_i[gnt_port];
      mem_wdata_o = bus.wdata_i[gnt_port];
      // Only reads return data; the tag marks which port owns next cycle's rdata.
      rvalid_d    = gnt & ~bus.we_i;
   end

   // FSM state and read-response tag registers.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q  <= ARB_IDLE;
         rvalid_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
      end
   end

   // The tag is masked during reset so a read issued just before reset
   // never surfaces, not even in the reset cycle itself.
   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = rvalid_q & {2{reset_b}};
   assign bus.rdata_o  = mem_rdata_i;

   // Grant is at most one-hot and only to a requesting port.
   a_gnt_legal : assert property (@(posedge clk)
      $onehot0(gnt) && ((gnt & ~bus.req_i) == 2'b00));

   // Memory is selected exactly when a grant is issued.
   a_cs_matches_gnt : assert property (@(posedge clk)
      mem_cs_o == (gnt != 2'b00));

   // A write never raises a response tag.
   a_write_no_rvalid : assert property (@(posedge clk) disable iff (!reset_b)
      mem_we_o |=> (rvalid_q == 2'b00));

   // Nothing is granted while reset is held.
   a_reset_quiet : assert property (@(posedge clk)
      !reset_b |-> (gnt == 2'b00));

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, data width of both ports and the memory.
REQ-002 Parameter ADDR_W, default 10, byte-address width of both ports and the memory.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-004 Ports, as name / direction / width / meaning:
- clk  in  1  rising-edge clock.
- reset_b  in  1  synchronous active-low reset.
- req_i[1:0]  in  2  access request; port 0 = CPU, port 1 = debug/dump.
- lock_i[1:0]  in  2  hold the grant on following cycles.
- we_i[1:0]  in  2  1 = write, 0 = read.
- addr_i[2][ADDR_W]  in  request address.
- wdata_i[2][DATA_W]  in  write data.
- gnt_o[1:0]  out  2  access issued this cycle.
- rvalid_o[1:0]  out  2  read data valid.
- rdata_o[DATA_W]  out  shared read-data bus.
- mem_cs_o  out  1  memory select.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid 1 cycle after a read with mem_cs_o=1.

Function
REQ-005 At most one gnt_o bit SHALL be high per cycle, and only for a port whose req_i is high.
REQ-006 Grant is combinational in the request cycle: gnt_o[p]=1 drives mem_cs_o=1 and muxes we_i/addr_i/wdata_i[p] onto mem_*_o in that same cycle.
REQ-007 With no grant: mem_cs_o=0, mem_we_o=0; mem_addr_o and mem_wdata_o are don't-care.
REQ-008 Read latency SHALL be 1 cycle.
- A granted read on port p asserts rvalid_o[p] in the next cycle, for exactly one cycle.
- In that cycle, rdata_o=mem_rdata_i.
REQ-009 Writes SHALL produce no rvalid_o.
REQ-010 rvalid_o SHALL be routed by a registered port tag, so back-to-back reads to alternating ports return data to the correct port.
REQ-011 Round-robin arbitration: a 1-bit pointer rr_q names the preferred port.
- If both ports request, grant port rr_q.
- After any unlocked grant to port p, rr_q becomes ~p.
REQ-012 FSM states: ARB_IDLE, ARB_LOCK0, ARB_LOCK1.
REQ-013 ARB_IDLE: normal arbitration per REQ-011.
- Grant to p with lock_i[p]=1 -> ARB_LOCKp.
REQ-014 ARB_LOCKp: only port p may be granted.
- Stay while req_i[p]&lock_i[p].
- Else -> ARB_IDLE and set rr_q=~p.
- The exit cycle SHALL still grant p if req_i[p]=1.
REQ-015 A request to the other port while in ARB_LOCKp is held off (gnt_o=0) and is not lost; the requester keeps req_i high.
REQ-016 A single requester SHALL be granted every cycle (full throughput, no bubbles).

Reset
REQ-017 While reset_b=0 at a rising clk edge:
- FSM goes to ARB_IDLE.
- rr_q goes to 0.
- rvalid_o goes to 2'b00.
REQ-018 gnt_o and mem_cs_o SHALL be 0 whenever reset_b=0, regardless of req_i.
REQ-019 A read granted in the cycle before reset asserts SHALL NOT produce rvalid_o after reset.

Configuration
REQ-020 Macro DMEM_ARB_FIXED_PRI_EN.
- Defined: port 0 always wins a simultaneous request; rr_q is removed; lock behaviour is unchanged.
- Undefined: round-robin per REQ-011.

Structure
REQ-021 Shared package dmem_arb_pkg SHALL hold:
- the arb_state_e enum (ARB_IDLE, ARB_LOCK0, ARB_LOCK1);
- the port index constants PORT_CPU=0 and PORT_DBG=1;
- default DATA_W/ADDR_W localparams.
REQ-022 One sub-module, dmem_arb_rr, SHALL hold the 2-way grant logic plus rr_q; the FSM, muxes and response tag live in dmem_arbiter.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset with req_i=2'b11 -> gnt_o=0, mem_cs_o=0; first cycle after release: gnt_o=2'b01.
- Both ports request reads continuously, addr 0x08 / 0x10 -> gnt_o alternates 01,10,01; rvalid_o follows one cycle later with matching data.
- Port 0 writes 0xDEADBEEF_00000001 at 0x18, then port 1 reads 0x18 -> rvalid_o=2'b10, rdata_o=0xDEADBEEF_00000001.
- Port 1 holds lock_i for 4 cycles while port 0 requests -> four grants to port 1; the next cycle grants port 0.
- Port 0 alone requests for 5 cycles -> gnt_o[0]=1 on all 5 cycles.
- Reset asserted the cycle after a read grant -> no rvalid_o.
- Compile with DMEM_ARB_FIXED_PRI_EN, both ports requesting -> port 0 granted every cycle.
